// File: rtl/mux_16_1_input1bit.sv
`default_nettype none
// ============================================================================
//  Module      : mux_16_1_input1bit
//  Description : 16:1 single-bit multiplexer built as a 4-level tree of 2:1
//                selections, with a registered output (1-cycle latency) and
//                a synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_16_1_input1bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       X0,
    input  logic       X1,
    input  logic       X2,
    input  logic       X3,
    input  logic       X4,
    input  logic       X5,
    input  logic       X6,
    input  logic       X7,
    input  logic       X8,
    input  logic       X9,
    input  logic       X10,
    input  logic       X11,
    input  logic       X12,
    input  logic       X13,
    input  logic       X14,
    input  logic       X15,
    input  logic [3:0] S,
    output logic       OUT
);

    localparam int c_NUM_IN = 16;

    // Data inputs gathered into a vector so the tree can be generated;
    // index n holds Xn, so S directly addresses the selected input.
    logic [c_NUM_IN-1:0] w_x;
    logic [7:0]          w_l0;   // level 0: S[0] picks within each pair
    logic [3:0]          w_l1;   // level 1: S[1]
    logic [1:0]          w_l2;   // level 2: S[2]
    logic                w_sel;  // level 3: S[3], final selected bit
    logic                r_out;

    assign w_x = {X15, X14, X13, X12, X11, X10, X9, X8,
                  X7,  X6,  X5,  X4,  X3,  X2,  X1, X0};

    // Each level is a plain 2:1 select, so every S code has a defined path
    // and known inputs always give a known result.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_lvl0
            assign w_l0[i] = S[0] ? w_x[2*i+1] : w_x[2*i];
        end
        for (genvar i = 0; i < 4; i++) begin : g_lvl1
            assign w_l1[i] = S[1] ? w_l0[2*i+1] : w_l0[2*i];
        end
        for (genvar i = 0; i < 2; i++) begin : g_lvl2
            assign w_l2[i] = S[2] ? w_l1[2*i+1] : w_l1[2*i];
        end
    endgenerate

    assign w_sel = S[3] ? w_l2[1] : w_l2[0];

    // Output register: reset wins over the load; the load happens every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_sel;
        end
    end

    assign OUT = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mux_16_1_input1bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_16_1_input1bit
//  Description : Self-checking bench for mux_16_1_input1bit. Expected values
//                are queued when stimulus is driven (negedge) and compared
//                one rising edge later, 1 time unit after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_16_1_input1bit;

    logic        clk;
    logic        rst;
    logic [15:0] tb_x;
    logic [3:0]  tb_s;
    logic        OUT;

    int   n_total;
    int   n_bad;
    logic sb_q[$];

    mux_16_1_input1bit u_dut (
        .clk (clk),
        .rst (rst),
        .X0  (tb_x[0]),
        .X1  (tb_x[1]),
        .X2  (tb_x[2]),
        .X3  (tb_x[3]),
        .X4  (tb_x[4]),
        .X5  (tb_x[5]),
        .X6  (tb_x[6]),
        .X7  (tb_x[7]),
        .X8  (tb_x[8]),
        .X9  (tb_x[9]),
        .X10 (tb_x[10]),
        .X11 (tb_x[11]),
        .X12 (tb_x[12]),
        .X13 (tb_x[13]),
        .X14 (tb_x[14]),
        .X15 (tb_x[15]),
        .S   (tb_s),
        .OUT (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply stimulus on the falling edge and queue the expected OUT value.
    task automatic drive(input logic [15:0] x, input logic [3:0] s,
                         input logic r, input logic exp);
        @(negedge clk);
        tb_x = x;
        tb_s = s;
        rst  = r;
        sb_q.push_back(exp);
    endtask

    // Let the rising edge happen, then pop and compare one expected value.
    task automatic capture(input string tag);
        logic e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %b expected a queued value", tag, OUT);
        end else begin
            e = sb_q.pop_front();
            check_bit(tag, OUT, e);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] rnd;
        n_total = 0;
        n_bad   = 0;
        tb_x    = 16'h0000;
        tb_s    = 4'd0;
        rst     = 1'b1;

        // Reset state, with a live input that would otherwise be loaded.
        drive(16'hFFFF, 4'd7, 1'b1, 1'b0);
        capture("reset_state");

        // One-hot sweep: OUT = 1 exactly when k == S.
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 16; k++) begin
                pat = 16'h0001 << k;
                drive(pat, 4'(s), 1'b0, (k == s));
                capture($sformatf("onehot_s%0d_k%0d", s, k));
            end
        end

        // Inverse one-hot sweep: OUT = 0 exactly when k == S.
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 16; k++) begin
                pat = ~(16'h0001 << k);
                drive(pat, 4'(s), 1'b0, (k != s));
                capture($sformatf("invhot_s%0d_k%0d", s, k));
            end
        end

        // Reset check: S = 5, X5 = 1. OUT must hold between edges while
        // rst is high, clear on the edge, then reload after release.
        drive(16'h0020, 4'd5, 1'b0, 1'b1);
        capture("rst_preload");
        drive(16'h0020, 4'd5, 1'b1, 1'b0);
        #1;
        check_bit("rst_no_async", OUT, 1'b1);
        capture("rst_assert");
        drive(16'h0020, 4'd5, 1'b0, 1'b1);
        capture("rst_release");

        // Latency: X3 rises between edges; OUT changes only at the edge.
        drive(16'h0000, 4'd3, 1'b0, 1'b0);
        capture("lat_base");
        drive(16'h0008, 4'd3, 1'b0, 1'b1);
        #1;
        check_bit("lat_before_edge", OUT, 1'b0);
        capture("lat_after_edge");

        // Isolation: S = 15, X15 = 1, X0..X14 random.
        for (int c = 0; c < 20; c++) begin
            rnd = 16'($urandom);
            drive({1'b1, rnd[14:0]}, 4'd15, 1'b0, 1'b1);
            capture($sformatf("iso_c%0d", c));
        end

        // Simultaneous change of S and selected input: X2 = 1, X9 = 0.
        drive(16'h0004, 4'd2, 1'b0, 1'b1);
        capture("simul_s2");
        drive(16'h0004, 4'd9, 1'b0, 1'b0);
        capture("simul_s9");

        // Mid-stream reset discards the selection in flight.
        drive(16'h0100, 4'd8, 1'b0, 1'b1);
        capture("mid_load");
        drive(16'h0100, 4'd8, 1'b1, 1'b0);
        capture("mid_reset");
        drive(16'h0100, 4'd8, 1'b0, 1'b1);
        capture("mid_resume");

        if (sb_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_16_1_input1bit.md
MUX_16_1_INPUT1BIT -- requirements
Module: mux_16_1_input1bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port `clk` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port `rst` SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Ports `X0` .. `X15` SHALL be inputs, 1 bit wide each: data inputs, with `Xn` selected when S = n.
REQ-006 Port `S` SHALL be an input, 4 bits wide, [3:0]: select code, unsigned 0..15.
REQ-007 Port `OUT` SHALL be an output, 1 bit wide: the registered selected data bit.

Function
REQ-008 The selection SHALL be combinational: sel_bit = X[S], with S interpreted as unsigned and X0 at S = 4'b0000 through X15 at S = 4'b1111.
REQ-009 The selection SHALL be built as a 4-level tree of 2:1 selections:
- level 0: S[0] picks between pairs (X0,X1), (X2,X3) .. (X14,X15);
- level 1: S[1] picks among the 8 level-0 results;
- level 2: S[2] picks among the 4 level-1 results;
- level 3: S[3] picks between the 2 level-2 results.
REQ-010 `OUT` SHALL be a register loaded with sel_bit on every rising clk edge when rst = 0.
REQ-011 Latency SHALL be exactly 1 clock: `OUT` after edge k equals X[S] as sampled just before edge k.
REQ-012 There SHALL be no enable and no handshake; a new selection is accepted every cycle.
REQ-013 Non-selected inputs SHALL have no effect on `OUT`, including when they toggle in the same cycle.
REQ-014 When S and the selected input change together before an edge, `OUT` SHALL reflect the new S with the new input value at that edge.
REQ-015 All 16 S codes SHALL be valid; there is no default or illegal-code path, and no latch is inferred.
REQ-016 The internal tree SHALL produce no X-propagation for fully known S and X inputs.

Reset
REQ-017 When rst = 1 at a rising clk edge, `OUT` SHALL become 0, regardless of S and X.
REQ-018 Reset SHALL take priority over the load of REQ-010.
REQ-019 Reset SHALL NOT act asynchronously; between edges `OUT` holds its value even while rst = 1.
REQ-020 On the first edge with rst = 0 after reset, `OUT` SHALL load X[S] normally.
REQ-021 Reset asserted mid-stream SHALL force `OUT` = 0 on that edge, and the selection in flight is discarded.

Verification
REQ-022 The bench SHALL run a one-hot sweep:
- for each S in 0..15, apply each of the 16 one-hot patterns {X15..X0} = 1<<k, one per cycle;
- after one clock, require `OUT` = 1 exactly when k = S, else 0 (256 checks).
REQ-023 The bench SHALL run an inverse one-hot sweep: {X15..X0} = ~(1<<k) for all S and k, requiring `OUT` = 0 exactly when k = S, else 1.
REQ-024 The bench SHALL check reset:
- with S = 5 and X5 = 1, assert rst for one edge and require `OUT` = 0;
- deassert rst and require `OUT` = 1 one edge later.
REQ-025 The bench SHALL check latency: with S = 3, toggle X3 0->1 between edges and require `OUT` to still show 0 before the edge and 1 after it.
REQ-026 The bench SHALL check non-selected isolation: with S = 15 and X15 = 1, toggle X0..X14 randomly for 20 cycles and require `OUT` = 1 throughout.
REQ-027 The bench SHALL check simultaneous change: switch S from 2 to 9 with X2 = 1 and X9 = 0 before one edge, and require `OUT` = 0 after that edge.
